// File: rtl/serial_frame_loader_pkg.sv
// Shared sizes and FSM state encoding for the serial frame loader.
package frame_loader_pkg;

  localparam int KEY_SIZE_DEF = 8;
  localparam int MSG_SIZE_DEF = 64;
  localparam int CNT_W        = $clog2(MSG_SIZE_DEF + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    LOAD_MSG = 2'd2,
    DRAIN    = 2'd3
  } fl_state_e;

endpackage

// File: rtl/serial_frame_loader_if.sv
// Pad-side inputs and core-side key/message/status outputs of the frame loader.
interface serial_frame_loader_if
  import frame_loader_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int MSG_SIZE = MSG_SIZE_DEF
);
  logic                ena;
  logic                ser_in;
  logic                key_load;
  logic                msg_load;
  logic                msg_ack;
  logic [KEY_SIZE-1:0] key_out;
  logic                key_valid;
  logic [MSG_SIZE-1:0] msg_out;
  logic                msg_valid;
  logic                busy;
  logic                err_short;
  logic                err_long;

  modport master (
    output ena, ser_in, key_load, msg_load, msg_ack,
    input  key_out, key_valid, msg_out, msg_valid, busy, err_short, err_long
  );

  modport slave (
    input  ena, ser_in, key_load, msg_load, msg_ack,
    output key_out, key_valid, msg_out, msg_valid, busy, err_short, err_long
  );
endinterface

// File: rtl/serial_frame_loader_sipo.sv
// Enable-gated MSB-first serial-in/parallel-out shifter with saturating bit counter.
module sipo_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] frame_nxt_o,
  output logic             full_o
);
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;

  // frame_nxt_o is the register content including the bit sampled on this edge
  assign frame_nxt_o = {sr_q[WIDTH-2:0], bit_i};
  assign full_o      = shift_i && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else if (shift_i) begin
        sr_q <= frame_nxt_o;
        if (cnt_q != CNT_W'(WIDTH))
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/serial_frame_loader.sv
// Deserializes key and message frames from the serial pad and presents them to the cipher core.
module serial_frame_loader
  import frame_loader_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_DEF,
  parameter int MSG_SIZE = MSG_SIZE_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_frame_loader_if.slave bus
);
  localparam int CW = $clog2(MSG_SIZE + 1);

  fl_state_e           state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [MSG_SIZE-1:0] msg_q, msg_d;
  logic                key_vld_q, key_vld_d;
  logic                msg_vld_q, msg_vld_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                drain_msg_q, drain_msg_d;
  logic                msg_blk_q, msg_blk_d;
  logic                key_shift, msg_shift, clr;
  logic                key_full, msg_full, drain_active;
  logic [KEY_SIZE-1:0] key_frame;
  logic [MSG_SIZE-1:0] msg_frame;

  sipo_shift_reg #(.WIDTH(KEY_SIZE), .CNT_W(CW)) u_key_sr (
    .clk(clk), .rst_n(rst_n), .en_i(bus.ena), .clr_i(clr), .shift_i(key_shift),
    .bit_i(bus.ser_in), .frame_nxt_o(key_frame), .full_o(key_full)
  );

  sipo_shift_reg #(.WIDTH(MSG_SIZE), .CNT_W(CW)) u_msg_sr (
    .clk(clk), .rst_n(rst_n), .en_i(bus.ena), .clr_i(clr), .shift_i(msg_shift),
    .bit_i(bus.ser_in), .frame_nxt_o(msg_frame), .full_o(msg_full)
  );

  assign drain_active = drain_msg_q ? bus.msg_load : bus.key_load;
  assign clr          = (state_q != IDLE) && (state_d == IDLE);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_vld_d   = key_vld_q;
    msg_d       = msg_q;
    msg_vld_d   = msg_vld_q && !bus.msg_ack;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    drain_msg_d = drain_msg_q;
    // A msg_load seen together with key_load must drop before it can start a frame
    msg_blk_d   = msg_blk_q && bus.msg_load;
    key_shift   = 1'b0;
    msg_shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.key_load) begin
          key_shift = 1'b1;
          msg_blk_d = bus.msg_load;
          state_d   = LOAD_KEY;
        end else if (bus.msg_load && !msg_blk_q) begin
          if (!msg_vld_q) begin
            msg_shift = 1'b1;
            state_d   = LOAD_MSG;
          end else begin
            err_long_d  = 1'b1;
            drain_msg_d = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      LOAD_KEY: begin
        if (bus.key_load) begin
          key_shift = 1'b1;
          if (key_full) begin
            key_d       = key_frame;
            key_vld_d   = 1'b1;
            drain_msg_d = 1'b0;
            state_d     = DRAIN;
          end
        end else begin
          err_short_d = 1'b1;
          state_d     = IDLE;
        end
      end
      LOAD_MSG: begin
        if (bus.msg_load) begin
          msg_shift = 1'b1;
          if (msg_full) begin
            msg_d       = msg_frame;
            msg_vld_d   = 1'b1;
            drain_msg_d = 1'b1;
            state_d     = DRAIN;
          end
        end else begin
          err_short_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (drain_active)
          err_long_d = 1'b1;
        else if (!bus.key_load && !bus.msg_load)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_vld_q   <= 1'b0;
      msg_q       <= '0;
      msg_vld_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      drain_msg_q <= 1'b0;
      msg_blk_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_vld_q   <= key_vld_d;
      msg_q       <= msg_d;
      msg_vld_q   <= msg_vld_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      drain_msg_q <= drain_msg_d;
      msg_blk_q   <= msg_blk_d;
    end
  end

  assign bus.key_out   = key_q;
  assign bus.key_valid = key_vld_q;
  assign bus.msg_out   = msg_q;
  assign bus.msg_valid = msg_vld_q;
  assign bus.busy      = (state_q == LOAD_KEY) || (state_q == LOAD_MSG);
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;
endmodule
